// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO feeding a registered RV32I decoder.
// Optional DECODE_ILLEGAL_TRAP_EN: present unsupported opcodes and stall on them.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      operatorType,
  output logic [2:0]      operatorSubType,
  output logic            operatorFlag,
  output logic [4:0]      reg1,
  output logic [4:0]      reg2,
  output logic [4:0]      destreg,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            regWrite,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_queue supports XLEN=32 only");
  end

  typedef struct packed {
    logic [6:0]  ty;
    logic [2:0]  sub;
    logic        flag;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rw;
    logic        ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic shift;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    // funct3 001 (SLLI) and 101 (SRLI/SRAI)
    shift = (i[13:12] == 2'b01);
    d = '0;
    d.ty = i[6:0];
    unique case (i[6:0])
      7'b0110111, 7'b0010111: begin
        d.rd = i[11:7];
        d.d1 = imm_u;
      end
      7'b1101111: begin
        d.rd = i[11:7];
        d.d1 = imm_j;
      end
      7'b1100111, 7'b0000011: begin
        d.rd  = i[11:7];
        d.r1  = i[19:15];
        d.sub = i[14:12];
        d.d2  = imm_i;
      end
      7'b1100011: begin
        d.r1  = i[19:15];
        d.r2  = i[24:20];
        d.sub = i[14:12];
        d.d2  = imm_b;
      end
      7'b0100011: begin
        d.r1  = i[19:15];
        d.r2  = i[24:20];
        d.sub = i[14:12];
        d.d2  = imm_s;
      end
      7'b0010011: begin
        d.rd   = i[11:7];
        d.r1   = i[19:15];
        d.sub  = i[14:12];
        d.flag = shift & i[30];
        d.d2   = shift ? {27'b0, i[24:20]} : imm_i;
      end
      7'b0110011: begin
        d.rd   = i[11:7];
        d.r1   = i[19:15];
        d.r2   = i[24:20];
        d.sub  = i[14:12];
        d.flag = i[30];
      end
      7'b0001111: begin
        d.sub = i[14:12];
        d.d2  = {24'b0, i[27:20]};
      end
      default: d.ill = 1'b1;
    endcase
    d.rw = (d.rd != 5'd0);
    return d;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [XLEN+31:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  dec_t             dec_q, dec_d, dec_s;
  logic [XLEN-1:0]  pc_q, pc_d, src_pc;
  logic [31:0]      ins_q, ins_d, src_ins;
  logic             push, load, pop, bypass, wr, hold;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign hold = valid_q & dec_q.ill;
`else
  assign hold = 1'b0;
`endif

  assign in_ready = !reset && (count_q < CW'(DEPTH));

  always_comb begin
    push   = in_valid && in_ready && !flush;
    load   = (!valid_q || out_ready) && !hold && !flush;
    pop    = load && (count_q != '0);
    bypass = load && (count_q == '0) && push;
    wr     = push && !bypass;
    {src_pc, src_ins} = pop ? mem_q[head_q] : {in_pc, in_instr};
    dec_s   = decode(src_ins);
    head_d  = pop ? nxt(head_q) : head_q;
    tail_d  = wr ? nxt(tail_q) : tail_q;
    count_d = count_q + CW'(wr) - CW'(pop);
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else if (pop || bypass) begin
      valid_d = 1'b1;
`ifndef DECODE_ILLEGAL_TRAP_EN
      valid_d = !dec_s.ill;
`endif
      if (valid_d) begin
        dec_d = dec_s;
        pc_d  = src_pc;
        ins_d = src_ins;
      end
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      ins_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[tail_q] <= {in_pc, in_instr};
  end

  assign out_valid       = valid_q;
  assign operatorType    = dec_q.ty;
  assign operatorSubType = dec_q.sub;
  assign operatorFlag    = dec_q.flag;
  assign reg1            = dec_q.r1;
  assign reg2            = dec_q.r2;
  assign destreg         = dec_q.rd;
  assign data1           = dec_q.d1;
  assign data2           = dec_q.d2;
  assign regWrite        = dec_q.rw;
  assign illegal         = dec_q.ill;
  assign pc_out          = pc_q;
  assign instr_out       = ins_q;

endmodule
